// File: rtl/hamming74_dec_arb_if.sv
// Request/response bundle for the shared Hamming(7,4) decoder arbiter.
// Direction prefixes on member names follow the block's port list.
interface hamming74_dec_arb_if #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 3,
  parameter int CNT_W = 16
);
  logic [N_CH-1:0]   i_req_valid;
  logic [N_CH*7-1:0] i_req_code;
  logic [N_CH-1:0]   i_req_tag;
  logic [N_CH-1:0]   o_req_ready;
  logic              o_valid;
  logic              i_ready;
  logic [3:0]        o_data;
  logic              o_tag;
  logic [CH_W-1:0]   o_ch;
  logic              o_err;
  logic              i_cnt_clr;
  logic [CNT_W-1:0]  o_err_cnt;

  modport slave (
    input  i_req_valid, i_req_code, i_req_tag, i_ready, i_cnt_clr,
    output o_req_ready, o_valid, o_data, o_tag, o_ch, o_err, o_err_cnt
  );

  modport master (
    output i_req_valid, i_req_code, i_req_tag, i_ready, i_cnt_clr,
    input  o_req_ready, o_valid, o_data, o_tag, o_ch, o_err, o_err_cnt
  );
endinterface

// File: rtl/hamming74_dec_arb.sv
// Round-robin arbiter in front of one Hamming(7,4) single-error-correcting decoder,
// with a registered output stage and a saturating corrected-word counter.
module hamming74_dec_arb #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 3,
  parameter int CNT_W = 16
) (
  input logic                i_clk,
  input logic                i_rst_n,
  hamming74_dec_arb_if.slave bus
);

  // Returns {err, data}; a nonzero syndrome names the 1-based position to flip.
  function automatic logic [4:0] hamming74_dec(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] fixed;
    s[0]  = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1]  = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2]  = c[3] ^ c[4] ^ c[5] ^ c[6];
    fixed = (s != 3'd0) ? (c ^ (7'd1 << (s - 3'd1))) : c;
    return {(s != 3'd0), fixed[6], fixed[5], fixed[4], fixed[2]};
  endfunction

  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  sel;
  logic             hit;
  logic             slot_free;
  logic             take;
  logic [6:0]       code;
  logic             tag;
  logic [4:0]       dec;
  logic [CNT_W-1:0] cnt_max;

  assign slot_free = !bus.o_valid || bus.i_ready;
  assign take      = hit && slot_free && i_rst_n;
  assign dec       = hamming74_dec(code);
  assign cnt_max   = {CNT_W{1'b1}};

  assign bus.o_req_ready = take ? (N_CH'(1) << sel) : '0;

  // Pick the first requester at or above ptr, else the first one below it.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      sel = (!hit && bus.i_req_valid[k] && (CH_W'(k) >= ptr)) ? CH_W'(k) : sel;
      hit = hit || (bus.i_req_valid[k] && (CH_W'(k) >= ptr));
    end
    for (int k = 0; k < N_CH; k++) begin
      sel = (!hit && bus.i_req_valid[k]) ? CH_W'(k) : sel;
      hit = hit || bus.i_req_valid[k];
    end
  end

  // Steer the granted channel's codeword and tag into the shared decoder.
  always_comb begin
    code = 7'd0;
    tag  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      code = (CH_W'(k) == sel) ? bus.i_req_code[k*7 +: 7] : code;
      tag  = (CH_W'(k) == sel) ? bus.i_req_tag[k] : tag;
    end
  end

  // Round-robin pointer advances past each accepted channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (sel == CH_W'(N_CH - 1)) ? '0 : (sel + CH_W'(1));
    end else begin
      ptr <= ptr;
    end
  end

  // Output register: reload on accept, drop valid once consumed, hold data otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_data  <= 4'd0;
      bus.o_tag   <= 1'b0;
      bus.o_ch    <= '0;
      bus.o_err   <= 1'b0;
    end else if (take) begin
      bus.o_valid <= 1'b1;
      bus.o_data  <= dec[3:0];
      bus.o_tag   <= tag;
      bus.o_ch    <= sel;
      bus.o_err   <= dec[4];
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end else begin
      bus.o_valid <= bus.o_valid;
    end
  end

  // Corrected-word counter; clear wins over a coincident increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_err_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      bus.o_err_cnt <= '0;
    end else if (take && dec[4] && (bus.o_err_cnt != cnt_max)) begin
      bus.o_err_cnt <= bus.o_err_cnt + CNT_W'(1);
    end else begin
      bus.o_err_cnt <= bus.o_err_cnt;
    end
  end

endmodule

// File: tb/tb_hamming74_dec_arb.sv
// Directed bench for hamming74_dec_arb: grant order, decode, backpressure,
// counter saturation/clear and reset mid-stream, with hand-computed expectations.
module tb_hamming74_dec_arb;
  localparam int N_CH  = 4;
  localparam int CH_W  = 3;
  localparam int CNT_W = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hamming74_dec_arb_if #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  hamming74_dec_arb #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic [6:0] c, input logic t);
    bus.i_req_valid[ch]      = 1'b1;
    bus.i_req_code[ch*7 +: 7] = c;
    bus.i_req_tag[ch]        = t;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Clean codewords: ch0 -> 4'h1, ch1 -> 4'h2, ch2 -> 4'h4, ch3 -> 4'h8
  logic [6:0] rr_code [4];
  logic [3:0] rr_data [4];

  initial begin
    total = 0;
    bad   = 0;
    rr_code[0] = 7'h07; rr_data[0] = 4'h1;
    rr_code[1] = 7'h19; rr_data[1] = 4'h2;
    rr_code[2] = 7'h2A; rr_data[2] = 4'h4;
    rr_code[3] = 7'h4B; rr_data[3] = 4'h8;

    rst_n           = 1'b0;
    bus.i_req_valid = 4'hF;
    bus.i_req_code  = '0;
    bus.i_req_tag   = '0;
    bus.i_ready     = 1'b1;
    bus.i_cnt_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_cnt", 32'(bus.o_err_cnt), 32'd0);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd0);

    // single clean word on channel 2
    rst_n           = 1'b1;
    bus.i_req_valid = 4'h0;
    set_req(2, 7'h7F, 1'b1);
    #1 chk("t1_grant", 32'(bus.o_req_ready), 32'h4);
    step();
    bus.i_req_valid = 4'h0;
    chk("t1_valid", 32'(bus.o_valid), 32'd1);
    chk("t1_data", 32'(bus.o_data), 32'hF);
    chk("t1_tag", 32'(bus.o_tag), 32'd1);
    chk("t1_ch", 32'(bus.o_ch), 32'd2);
    chk("t1_err", 32'(bus.o_err), 32'd0);
    chk("t1_cnt", 32'(bus.o_err_cnt), 32'd0);

    // corrected error on ch0 (ptr=3, wraps), then clean zero on ch1
    set_req(0, 7'h6F, 1'b0);
    #1 chk("t2_grant", 32'(bus.o_req_ready), 32'h1);
    step();
    bus.i_req_valid = 4'h0;
    chk("t2_data", 32'(bus.o_data), 32'hF);
    chk("t2_err", 32'(bus.o_err), 32'd1);
    chk("t2_cnt", 32'(bus.o_err_cnt), 32'd1);
    chk("t2_tag", 32'(bus.o_tag), 32'd0);
    set_req(1, 7'h00, 1'b0);
    step();
    bus.i_req_valid = 4'h0;
    chk("t3_data", 32'(bus.o_data), 32'h0);
    chk("t3_err", 32'(bus.o_err), 32'd0);
    chk("t3_ch", 32'(bus.o_ch), 32'd1);

    // one word on ch3 brings ptr back to 0
    set_req(3, 7'h4B, 1'b0);
    step();
    bus.i_req_valid = 4'h0;
    chk("t4_ch", 32'(bus.o_ch), 32'd3);

    // fairness: all channels requesting for 8 cycles
    for (int k = 0; k < 4; k++) set_req(k, rr_code[k], 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", 32'(bus.o_valid), 32'd1);
      chk("rr_ch", 32'(bus.o_ch), 32'(i % 4));
      chk("rr_data", 32'(bus.o_data), 32'(rr_data[i % 4]));
    end

    // backpressure with channels 1 and 3 requesting
    bus.i_ready     = 1'b0;
    bus.i_req_valid = 4'h0;
    set_req(1, rr_code[1], 1'b0);
    set_req(3, rr_code[3], 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(bus.o_req_ready), 32'd0);
      step();
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_ch", 32'(bus.o_ch), 32'd3);
      chk("bp_data", 32'(bus.o_data), 32'h8);
    end
    bus.i_ready = 1'b1;
    #1 chk("bp_grant", 32'(bus.o_req_ready), 32'h2);
    step();
    bus.i_req_valid = 4'h0;
    chk("bp_next_ch", 32'(bus.o_ch), 32'd1);
    chk("bp_next_data", 32'(bus.o_data), 32'h2);

    // counter clear, then saturation at 3
    bus.i_cnt_clr = 1'b1;
    step();
    bus.i_cnt_clr = 1'b0;
    chk("clr_cnt", 32'(bus.o_err_cnt), 32'd0);
    set_req(0, 7'h6F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_err", 32'(bus.o_err), 32'd1);
      chk("sat_cnt", 32'(bus.o_err_cnt), 32'((i < 3) ? (i + 1) : 3));
    end
    bus.i_cnt_clr = 1'b1;
    step();
    bus.i_cnt_clr   = 1'b0;
    bus.i_req_valid = 4'h0;
    chk("clr_inc_err", 32'(bus.o_err), 32'd1);
    chk("clr_inc_cnt", 32'(bus.o_err_cnt), 32'd0);
    step();
    chk("clr_hold_cnt", 32'(bus.o_err_cnt), 32'd0);

    // reset while a word is stalled
    set_req(2, 7'h7F, 1'b1);
    step();
    bus.i_req_valid = 4'h0;
    bus.i_ready     = 1'b0;
    chk("mr_valid_pre", 32'(bus.o_valid), 32'd1);
    #2 rst_n = 1'b0;
    bus.i_req_valid = 4'hF;
    #1;
    chk("mr_valid", 32'(bus.o_valid), 32'd0);
    chk("mr_data", 32'(bus.o_data), 32'd0);
    chk("mr_ch", 32'(bus.o_ch), 32'd0);
    chk("mr_ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, rr_code[k], 1'b0);
    #1 chk("mr_grant", 32'(bus.o_req_ready), 32'h1);
    step();
    chk("mr_ch0", 32'(bus.o_ch), 32'd0);
    chk("mr_valid_post", 32'(bus.o_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
